// File: rtl/cprv_mem_stage_if.sv
// cprv64g data-memory bus between the memory stage and memory.
// Request/acknowledge; request fields hold until ack.
`timescale 1ns/1ps
interface cprv_mem_stage_if #(
  parameter int DATA_WIDTH = 64
);
  logic                    req;
  logic                    we;
  logic [DATA_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [7:0]              wstrb;
  logic                    ack;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ack, rdata
  );
endinterface

// File: rtl/cprv_mem_stage.sv
// cprv64g memory stage: load/store bus access, load alignment/extension.
// Optional CPRV_MEM_MISALIGN_CHK_EN flags misaligned accesses and skips the bus.
`timescale 1ns/1ps
module cprv_mem_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int IMM_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_mem_i,
  output logic                  ready_mem_o,
  input  logic [DATA_WIDTH-1:0] alu_out_mem_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_mem_i,
  input  logic [4:0]            rd_addr_mem_i,
  input  logic                  rd_en_mem_i,
  input  logic [IMM_WIDTH-1:0]  imm_data_mem_i,
  input  logic [6:0]            opcode_mem_i,
  input  logic [2:0]            funct3_mem_i,
  input  logic [6:0]            funct7_mem_i,
  output logic                  valid_wb_o,
  input  logic                  ready_wb_i,
  output logic [4:0]            rd_addr_wb_o,
  output logic                  rd_en_wb_o,
  output logic [IMM_WIDTH-1:0]  imm_data_wb_o,
  output logic [6:0]            opcode_wb_o,
  output logic [2:0]            funct3_wb_o,
  output logic [6:0]            funct7_wb_o,
  output logic [DATA_WIDTH-1:0] alu_out_wb_o,
  output logic [DATA_WIDTH-1:0] mem_data_wb_o,
`ifdef CPRV_MEM_MISALIGN_CHK_EN
  output logic                  misalign_wb_o,
`endif
  cprv_mem_stage_if.master      dmem
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_HOLD
  } state_t;

  state_t state_q, state_d;

  logic                  accept;
  logic                  is_ls;
  logic                  mis;
  logic                  go_mem;
  logic                  in_mem;
  logic                  is_st;
  logic [2:0]            off;
  logic [7:0]            strb_base;
  logic [DATA_WIDTH-1:0] rs2_q;
  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] ext;

  assign ready_mem_o = (state_q == S_IDLE)
                     | ((state_q == S_HOLD) & ready_wb_i);
  assign accept = valid_mem_i & ready_mem_o;
  assign is_ls  = (opcode_mem_i == OP_LOAD)
                | (opcode_mem_i == OP_STORE);

`ifdef CPRV_MEM_MISALIGN_CHK_EN
  always_comb begin
    mis = 1'b0;
    case (funct3_mem_i[1:0])
      2'd1:    mis = alu_out_mem_i[0];
      2'd2:    mis = |alu_out_mem_i[1:0];
      2'd3:    mis = |alu_out_mem_i[2:0];
      default: mis = 1'b0;
    endcase
    mis = mis & is_ls;
  end
`else
  assign mis = 1'b0;
`endif

  assign go_mem = is_ls & ~mis;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = go_mem ? S_MEM : S_HOLD;
      S_MEM:  if (dmem.ack) state_d = S_HOLD;
      S_HOLD: begin
        if (accept)          state_d = go_mem ? S_MEM : S_HOLD;
        else if (ready_wb_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_wb_o  <= '0;
      rd_en_wb_o    <= 1'b0;
      imm_data_wb_o <= '0;
      opcode_wb_o   <= '0;
      funct3_wb_o   <= '0;
      funct7_wb_o   <= '0;
      alu_out_wb_o  <= '0;
      rs2_q         <= '0;
`ifdef CPRV_MEM_MISALIGN_CHK_EN
      misalign_wb_o <= 1'b0;
`endif
    end else if (accept) begin
      rd_addr_wb_o  <= rd_addr_mem_i;
      rd_en_wb_o    <= rd_en_mem_i & ~mis;
      imm_data_wb_o <= imm_data_mem_i;
      opcode_wb_o   <= opcode_mem_i;
      funct3_wb_o   <= funct3_mem_i;
      funct7_wb_o   <= funct7_mem_i;
      alu_out_wb_o  <= alu_out_mem_i;
      rs2_q         <= rs2_data_mem_i;
`ifdef CPRV_MEM_MISALIGN_CHK_EN
      misalign_wb_o <= mis;
`endif
    end
  end

  assign off    = alu_out_wb_o[2:0];
  assign in_mem = (state_q == S_MEM);
  assign is_st  = (opcode_wb_o == OP_STORE);
  assign sh     = dmem.rdata >> {off, 3'b000};

  always_comb begin
    ext = sh;
    case (funct3_wb_o)
      3'd0: ext = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
      3'd1: ext = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
      3'd2: ext = {{(DATA_WIDTH-32){sh[31]}}, sh[31:0]};
      3'd4: ext = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
      3'd5: ext = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
      3'd6: ext = {{(DATA_WIDTH-32){1'b0}}, sh[31:0]};
      default: ext = sh;
    endcase
  end

  // non-load results carry zero load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mem_data_wb_o <= '0;
    else if (accept)
      mem_data_wb_o <= '0;
    else if (in_mem & dmem.ack & (opcode_wb_o == OP_LOAD))
      mem_data_wb_o <= ext;
  end

  always_comb begin
    strb_base = 8'hFF;
    unique case (1'b1)
      (funct3_wb_o[1:0] == 2'd0): strb_base = 8'h01;
      (funct3_wb_o[1:0] == 2'd1): strb_base = 8'h03;
      (funct3_wb_o[1:0] == 2'd2): strb_base = 8'h0F;
      default:                    strb_base = 8'hFF;
    endcase
  end

  assign valid_wb_o = (state_q == S_HOLD);
  assign dmem.req   = in_mem;
  assign dmem.we    = in_mem & is_st;
  assign dmem.wstrb = (in_mem & is_st) ? (strb_base << off) : 8'h00;
  assign dmem.addr  = {alu_out_wb_o[DATA_WIDTH-1:3], 3'b000};
  assign dmem.wdata = rs2_q << {off, 3'b000};

endmodule

// File: tb/tb_cprv_mem_stage.sv
// Scoreboard bench for cprv_mem_stage: bus responder, wb monitor.
`timescale 1ns/1ps
module tb_cprv_mem_stage;

  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] AL_OP = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_mem_i = 1'b0;
  logic        ready_mem_o;
  logic [63:0] alu_out_mem_i = '0;
  logic [63:0] rs2_data_mem_i = '0;
  logic [4:0]  rd_addr_mem_i = '0;
  logic        rd_en_mem_i = 1'b0;
  logic [31:0] imm_data_mem_i = '0;
  logic [6:0]  opcode_mem_i = '0;
  logic [2:0]  funct3_mem_i = '0;
  logic [6:0]  funct7_mem_i = '0;
  logic        valid_wb_o;
  logic        ready_wb_i = 1'b1;
  logic [4:0]  rd_addr_wb_o;
  logic        rd_en_wb_o;
  logic [31:0] imm_data_wb_o;
  logic [6:0]  opcode_wb_o;
  logic [2:0]  funct3_wb_o;
  logic [6:0]  funct7_wb_o;
  logic [63:0] alu_out_wb_o;
  logic [63:0] mem_data_wb_o;

  cprv_mem_stage_if dmem ();

  cprv_mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_mem_i    (valid_mem_i),
    .ready_mem_o    (ready_mem_o),
    .alu_out_mem_i  (alu_out_mem_i),
    .rs2_data_mem_i (rs2_data_mem_i),
    .rd_addr_mem_i  (rd_addr_mem_i),
    .rd_en_mem_i    (rd_en_mem_i),
    .imm_data_mem_i (imm_data_mem_i),
    .opcode_mem_i   (opcode_mem_i),
    .funct3_mem_i   (funct3_mem_i),
    .funct7_mem_i   (funct7_mem_i),
    .valid_wb_o     (valid_wb_o),
    .ready_wb_i     (ready_wb_i),
    .rd_addr_wb_o   (rd_addr_wb_o),
    .rd_en_wb_o     (rd_en_wb_o),
    .imm_data_wb_o  (imm_data_wb_o),
    .opcode_wb_o    (opcode_wb_o),
    .funct3_wb_o    (funct3_wb_o),
    .funct7_wb_o    (funct7_wb_o),
    .alu_out_wb_o   (alu_out_wb_o),
    .mem_data_wb_o  (mem_data_wb_o),
    .dmem           (dmem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] alu;
    logic [4:0]  rd;
    logic        rd_en;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [63:0] mem;
    int          lat;
  } exp_t;

  exp_t   sb[$];
  longint acc_q[$];
  longint cyc = 0;
  int     req_cnt = 0;
  int     total = 0;
  int     bad = 0;
  exp_t   e;
  longint a;
  int     r0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // write-back side: pop expected record on every wb transfer
  always @(negedge clk) begin
    #3;
    if (rst_n && dmem.req) req_cnt++;
    if (rst_n && valid_wb_o && ready_wb_i) begin
      if (sb.size() == 0 || acc_q.size() == 0) begin
        chk("spurious_wb", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        a = acc_q.pop_front();
        chk("wb_alu", alu_out_wb_o, e.alu);
        chk("wb_rd", {59'd0, rd_addr_wb_o}, {59'd0, e.rd});
        chk("wb_rd_en", {63'd0, rd_en_wb_o}, {63'd0, e.rd_en});
        chk("wb_imm", {32'd0, imm_data_wb_o}, {32'd0, e.imm});
        chk("wb_op", {57'd0, opcode_wb_o}, {57'd0, e.op});
        chk("wb_f3", {61'd0, funct3_wb_o}, {61'd0, e.f3});
        chk("wb_mem", mem_data_wb_o, e.mem);
        if (e.lat >= 0)
          chk("wb_lat", 64'(cyc + 1 - a), 64'(e.lat));
      end
    end
  end

  task automatic send(
    input bit          sync,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [63:0] alu,
    input logic [63:0] rs2,
    input logic [4:0]  rd,
    input logic        rde,
    input int          ack_wait,
    input logic [63:0] rdata,
    input logic [63:0] exp_mem,
    input logic [7:0]  exp_strb,
    input logic [63:0] exp_wdata,
    input int          lat
  );
    exp_t x;
    bit   ok;
    x.alu = alu; x.rd = rd; x.rd_en = rde;
    x.imm = {27'd0, rd} + 32'h100;
    x.op = op; x.f3 = f3; x.mem = exp_mem; x.lat = lat;
    sb.push_back(x);
    if (sync) @(negedge clk);
    #1;
    valid_mem_i = 1'b1; opcode_mem_i = op; funct3_mem_i = f3;
    alu_out_mem_i = alu; rs2_data_mem_i = rs2;
    rd_addr_mem_i = rd; rd_en_mem_i = rde;
    imm_data_mem_i = x.imm; funct7_mem_i = 7'h20;
    #1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (ready_mem_o) begin
        ok = 1;
        break;
      end
      @(negedge clk); #2;
    end
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
      valid_mem_i = 1'b0;
      return;
    end
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    valid_mem_i = 1'b0;
    if (op == LD_OP || op == ST_OP) begin
      ok = 0;
      @(negedge clk); #2;
      for (int i = 0; i < 50; i++) begin
        if (dmem.req) begin
          ok = 1;
          break;
        end
        @(negedge clk); #2;
      end
      if (!ok) begin
        chk("req_timeout", 64'd0, 64'd1);
        return;
      end
      chk("addr", dmem.addr, {alu[63:3], 3'b000});
      chk("we", {63'd0, dmem.we}, {63'd0, op == ST_OP});
      chk("wstrb", {56'd0, dmem.wstrb}, {56'd0, exp_strb});
      if (op == ST_OP) chk("wdata", dmem.wdata, exp_wdata);
      for (int i = 0; i < ack_wait; i++) begin
        @(negedge clk); #2;
        chk("req_hold", {63'd0, dmem.req}, 64'd1);
        chk("addr_hold", dmem.addr, {alu[63:3], 3'b000});
      end
      dmem.ack = 1'b1;
      dmem.rdata = rdata;
      @(posedge clk); #1;
      dmem.ack = 1'b0;
      dmem.rdata = '0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk); #4;
    chk("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    dmem.ack = 1'b0;
    dmem.rdata = '0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_valid_wb", {63'd0, valid_wb_o}, 64'd0);
    chk("rst_req", {63'd0, dmem.req}, 64'd0);
    chk("rst_we", {63'd0, dmem.we}, 64'd0);
    chk("rst_wstrb", {56'd0, dmem.wstrb}, 64'd0);
    chk("rst_alu_wb", alu_out_wb_o, 64'd0);
    chk("rst_mem_wb", mem_data_wb_o, 64'd0);
    chk("rst_ready", {63'd0, ready_mem_o}, 64'd1);
    rst_n = 1'b1;

    // ALU op never touches the bus
    r0 = req_cnt;
    send(1, AL_OP, 3'd0, 64'h1234, 64'd0, 5'd5, 1'b1,
         0, 64'd0, 64'd0, 8'h00, 64'd0, 1);
    drain();
    chk("add_noreq", 64'(req_cnt), 64'(r0));

    send(1, LD_OP, 3'd0, 64'h1003, 64'd0, 5'd6, 1'b1,
         3, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80,
         8'h00, 64'd0, 5);
    drain();
    send(1, LD_OP, 3'd5, 64'h2006, 64'd0, 5'd7, 1'b1,
         0, 64'hBEEF0000_00000000, 64'h00000000_0000BEEF,
         8'h00, 64'd0, 2);
    drain();
    send(1, ST_OP, 3'd2, 64'h3004, 64'hDEADBEEF, 5'd0, 1'b0,
         0, 64'd0, 64'd0, 8'hF0, 64'hDEADBEEF_00000000, 2);
    drain();
    // word store crossing the doubleword keeps only fitting lanes
    send(1, ST_OP, 3'd2, 64'h4006, 64'h11223344, 5'd0, 1'b0,
         1, 64'd0, 64'd0, 8'hC0, 64'h33440000_00000000, 3);
    send(1, ST_OP, 3'd0, 64'h8001, 64'hAB, 5'd0, 1'b0,
         2, 64'd0, 64'd0, 8'h02, 64'h00000000_0000AB00, 4);
    send(1, LD_OP, 3'd2, 64'h5004, 64'd0, 5'd8, 1'b1,
         0, 64'h80000001_00000000, 64'hFFFFFFFF_80000001,
         8'h00, 64'd0, 2);
    send(1, LD_OP, 3'd3, 64'h6000, 64'd0, 5'd9, 1'b1,
         1, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF,
         8'h00, 64'd0, 3);
    send(1, LD_OP, 3'd1, 64'h9002, 64'd0, 5'd10, 1'b1,
         0, 64'h00000000_7FFF0000, 64'h00000000_00007FFF,
         8'h00, 64'd0, 2);
    send(1, LD_OP, 3'd6, 64'hA004, 64'd0, 5'd11, 1'b1,
         0, 64'hF0000000_00000000, 64'h00000000_F0000000,
         8'h00, 64'd0, 2);
    drain();

    // back-pressure in HOLD, then back-to-back load
    ready_wb_i = 1'b0;
    send(1, AL_OP, 3'd0, 64'h77, 64'd0, 5'd12, 1'b1,
         0, 64'd0, 64'd0, 8'h00, 64'd0, -1);
    valid_mem_i = 1'b1; opcode_mem_i = LD_OP; funct3_mem_i = 3'd3;
    alu_out_mem_i = 64'hB000; rd_addr_mem_i = 5'd13;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      chk("hold_valid", {63'd0, valid_wb_o}, 64'd1);
      chk("hold_alu", alu_out_wb_o, 64'h77);
      chk("hold_rd", {59'd0, rd_addr_wb_o}, 64'd12);
      chk("hold_ready", {63'd0, ready_mem_o}, 64'd0);
    end
    @(negedge clk); #1;
    ready_wb_i = 1'b1;
    #1;
    chk("hold_release_ready", {63'd0, ready_mem_o}, 64'd1);
    send(0, LD_OP, 3'd3, 64'hB000, 64'd0, 5'd13, 1'b1,
         0, 64'h55AA55AA_12345678, 64'h55AA55AA_12345678,
         8'h00, 64'd0, 2);
    drain();

    // reset while a load is waiting for ack
    @(negedge clk); #1;
    valid_mem_i = 1'b1; opcode_mem_i = LD_OP; funct3_mem_i = 3'd2;
    alu_out_mem_i = 64'h7000; rd_addr_mem_i = 5'd14;
    #1;
    chk("lw_ready", {63'd0, ready_mem_o}, 64'd1);
    @(posedge clk); #1;
    valid_mem_i = 1'b0;
    @(negedge clk); #2;
    chk("lw_req", {63'd0, dmem.req}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {63'd0, dmem.req}, 64'd0);
    chk("rst_mid_valid", {63'd0, valid_wb_o}, 64'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #2;
    chk("post_rst_ready", {63'd0, ready_mem_o}, 64'd1);
    chk("post_rst_req", {63'd0, dmem.req}, 64'd0);
    chk("post_rst_valid", {63'd0, valid_wb_o}, 64'd0);

    send(1, AL_OP, 3'd4, 64'hC0FFEE, 64'd0, 5'd15, 1'b1,
         0, 64'd0, 64'd0, 8'h00, 64'd0, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d want=0", 1);
    $fatal(1, "timeout");
  end

endmodule
